obs_mul163_seq: RTL

- Iterative GF(2)[x] 163-bit polynomial multiplier controller. Computes a 163-bit product using one shared 82-bit odd/even-split Karatsuba core, which it runs three times.
- Splits each operand into even and odd coefficient halves. Sequences the three half-products (even·even, odd·odd, mixed) through the core, then performs the odd/even recombination.
- Sits between the field-arithmetic front end (valid/ready operand stream) and the modular reduction stage. Trades three core passes for one third of the multiplier area.

---
 rtl/obs_mul163_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/obs_mul163_seq.sv
// obs_mul163_seq: 163-bit GF(2)[x] multiplier that runs an external 82-bit core three times with an odd/even Karatsuba split
module obs_mul163_seq #(
  parameter int N = 163,
  parameter int H = 82,
  parameter int CORE_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [H-1:0]   core_a,
  output logic [H-1:0]   core_b,
  input  logic [2*H-2:0] core_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y
);
  localparam logic [1:0] LAT = 2'(CORE_LAT > 3 ? 3 : CORE_LAT);
  typedef enum logic [2:0] {IDLE, EE, OO, MM, DONE} state_t;
  state_t r_state;
  logic [1:0] r_cnt;
  logic r_in_ready, r_out_valid;
  logic [2*N-2:0] r_y;
  logic [H-1:0] r_core_a, r_core_b;
  logic [H-1:0] r_ea, r_eb, r_oa, r_ob, r_ma, r_mb;
  logic [2*H-2:0] r_p1, r_p2;
  logic [H-1:0] w_ea, w_eb, w_oa, w_ob;
  logic [2*N-2:0] w_y;
  logic w_last;
  function automatic logic [2*N-2:0] spread(input logic [2*H-2:0] p);
    spread = '0;
    for (int i = 0; i < 2*H-1; i++) spread[2*i] = p[i];
  endfunction
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign w_last    = r_cnt == LAT;
  // even/odd coefficient halves of the incoming operands; the odd half's top bit stays zero
  always_comb begin
    w_ea = '0;
    w_eb = '0;
    w_oa = '0;
    w_ob = '0;
    for (int i = 0; i < H; i++) begin
      w_ea[i] = a[2*i];
      w_eb[i] = b[2*i];
    end
    for (int i = 0; i < N/2; i++) begin
      w_oa[i] = a[2*i+1];
      w_ob[i] = b[2*i+1];
    end
  end
  // recombination: P3 is taken straight from the core on the final MM cycle
  always_comb w_y = spread(r_p1) ^ (spread(r_p1 ^ r_p2 ^ core_y) << 1) ^ (spread(r_p2) << 2);
  // sequencer: three core passes, each held LAT+1 cycles, then hold the product until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_oa        <= '0;
      r_ob        <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_p1        <= '0;
      r_p2        <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_ea       <= w_ea;
          r_eb       <= w_eb;
          r_oa       <= w_oa;
          r_ob       <= w_ob;
          r_ma       <= w_ea ^ w_oa;
          r_mb       <= w_eb ^ w_ob;
          r_core_a   <= w_ea;
          r_core_b   <= w_eb;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= EE;
        end
        EE: begin
          r_cnt    <= w_last ? 2'd0 : r_cnt + 2'd1;
          r_core_a <= w_last ? r_oa : r_ea;
          r_core_b <= w_last ? r_ob : r_eb;
          if (w_last) begin
            r_p1    <= core_y;
            r_state <= OO;
          end
        end
        OO: begin
          r_cnt    <= w_last ? 2'd0 : r_cnt + 2'd1;
          r_core_a <= w_last ? r_ma : r_oa;
          r_core_b <= w_last ? r_mb : r_ob;
          if (w_last) begin
            r_p2    <= core_y;
            r_state <= MM;
          end
        end
        MM: begin
          r_cnt    <= w_last ? 2'd0 : r_cnt + 2'd1;
          r_core_a <= w_last ? '0 : r_ma;
          r_core_b <= w_last ? '0 : r_mb;
          if (w_last) begin
            r_y         <= w_y;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
